// File: rtl/tiny_thumb_mem.sv
// Word-organised RAM target for the Thumb core's valid/ready memory bus.
// One request at a time, with a fixed number of wait states before the ready pulse.
module tiny_thumb_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wstrb;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      result;
    logic             do_access;
    logic             unused_low_bits;

    // In IDLE the live bus is used so a zero-wait access completes in its capture cycle.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;
        if (state == S_IDLE) begin
            acc_we    = mem_we;
            acc_addr  = mem_addr;
            acc_wdata = mem_wdata;
            acc_wstrb = mem_wstrb;
        end
        offset   = acc_addr - BASE_ADDR;
        in_range = (acc_addr >= BASE_ADDR) && ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
        idx      = offset[IDX_W+1:2];
        result   = 32'd0;
        if (in_range && !acc_we) result = mem[idx];
        do_access = rst_n && mem_valid &&
                    (((state == S_IDLE) && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == 8'd1)));
    end

    assign unused_low_bits = ^offset[1:0];

    always_ff @(posedge clk) begin
        if (do_access && acc_we && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_wstrb[k]) mem[idx][8*k +: 8] <= acc_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            bus_err   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        we_q    <= mem_we;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        cnt     <= 8'(WAIT_CYCLES);
                        state   <= S_WAIT;
                        if (do_access) begin
                            state     <= S_RESP;
                            mem_ready <= 1'b1;
                            mem_rdata <= result;
                            if (!in_range) bus_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_valid) begin
                        state <= S_IDLE;
                    end else if (do_access) begin
                        state     <= S_RESP;
                        mem_ready <= 1'b1;
                        mem_rdata <= result;
                        if (!in_range) bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
